// File: rtl/tone_pkg.sv
// Shared constants for the tone bank: note half-period table, octave encoding
// and the half-period scaling helper used per channel.
package tone_pkg;

  localparam int CLK_HZ    = 100_000_000;
  localparam int NOTE_W    = 20;
  localparam int NUM_NOTES = 21;

  typedef enum logic [1:0] {
    OCT_BASE = 2'd0,
    OCT_UP   = 2'd1,
    OCT_DOWN = 2'd2,
    OCT_RSVD = 2'd3
  } oct_e;

  // Half periods in clk cycles for C3..B5 naturals: floor((CLK_HZ/2) / f).
  localparam logic [NOTE_W-1:0] NOTE_HALF_PERIOD [NUM_NOTES] = '{
    20'd382234, 20'd340529, 20'd303379, 20'd286352, 20'd255102, 20'd227272,
    20'd202478, 20'd191109, 20'd170264, 20'd151685, 20'd143172, 20'd127551,
    20'd113636, 20'd101239, 20'd95556,  20'd85131,  20'd75843,  20'd71586,
    20'd63776,  20'd56818,  20'd50619
  };

  function automatic logic [NOTE_W:0] scale_half_period(input logic [NOTE_W-1:0] h,
                                                        input oct_e oct);
    case (oct)
      OCT_UP:   return {2'b00, h[NOTE_W-1:1]};
      OCT_DOWN: return {h, 1'b0};
      default:  return {1'b0, h};
    endcase
  endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave voice: half-period counter plus toggle flop, held in phase
// reset (counter 0, tone low) whenever the channel is not enabled.
module tone_channel #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  output logic             tone
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tone_d = tone_q;
    if (!enable) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (cnt_q == half_period - CNT_W'(1)) begin
      cnt_d  = '0;
      tone_d = ~tone_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/tone_bank.sv
// Polyphonic square-wave bank: sticky voice allocation, octave register and
// per-key channels. The PWM mixer is built only when TONE_BANK_MIX_EN is defined.
module tone_bank
  import tone_pkg::*;
#(
  parameter int NUM_KEYS   = 21,
  parameter int CNT_W      = 20,
  parameter int MAX_VOICES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_KEYS-1:0]              key,
  input  logic [1:0]                       octave_sel,
  output logic [NUM_KEYS-1:0]              tone,
  output logic [$clog2(MAX_VOICES+1)-1:0]  active_cnt,
  output logic                             mix_pwm
);

  localparam int ACT_W  = $clog2(MAX_VOICES+1);
  localparam int KCNT_W = $clog2(NUM_KEYS+1);

  logic [NUM_KEYS-1:0] grant_q, grant_d;
  logic [KCNT_W-1:0]   used_cnt;
  oct_e                oct_q, oct_d;
  logic [CNT_W-1:0]    heff [NUM_KEYS];

  // Held voices are kept first, then free slots go to waiting keys lowest-index first.
  always_comb begin
    grant_d  = grant_q & key;
    used_cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      used_cnt = used_cnt + KCNT_W'(grant_d[i]);
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key[i] && !grant_d[i] && (used_cnt < KCNT_W'(MAX_VOICES))) begin
        grant_d[i] = 1'b1;
        used_cnt   = used_cnt + KCNT_W'(1);
      end
    end
  end

  always_comb begin
    oct_d = oct_q;
    if (grant_q == '0) begin
      if (octave_sel == OCT_UP)
        oct_d = OCT_UP;
      else if (octave_sel == OCT_DOWN)
        oct_d = OCT_DOWN;
      else
        oct_d = OCT_BASE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      oct_q   <= OCT_BASE;
    end else begin
      grant_q <= grant_d;
      oct_q   <= oct_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
      assign heff[gi] = CNT_W'(scale_half_period(NOTE_HALF_PERIOD[gi % NUM_NOTES], oct_q));

      tone_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .enable      (grant_q[gi]),
        .half_period (heff[gi]),
        .tone        (tone[gi])
      );
    end
  endgenerate

`ifdef TONE_BANK_MIX_EN
  logic [KCNT_W-1:0] high_cnt;
  logic [ACT_W-1:0]  active_q, active_d;
  logic [ACT_W-1:0]  pwm_q, pwm_d;
  logic              mix_q, mix_d;

  always_comb begin
    high_cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      high_cnt = high_cnt + KCNT_W'(tone[i] & grant_q[i]);
    end
    // Grant never exceeds MAX_VOICES, so the count always fits ACT_W.
    active_d = ACT_W'(high_cnt);
    pwm_d    = (pwm_q == ACT_W'(MAX_VOICES-1)) ? '0 : pwm_q + ACT_W'(1);
    mix_d    = (pwm_q < active_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      pwm_q    <= '0;
      mix_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      pwm_q    <= pwm_d;
      mix_q    <= mix_d;
    end
  end

  assign active_cnt = active_q;
  assign mix_pwm    = mix_q;
`else
  assign active_cnt = '0;
  assign mix_pwm    = 1'b0;
`endif

endmodule

// File: tb/tb_tone_bank.sv
// Directed bench for tone_bank: allocation vectors, octave register, tone
// timing in the raised octave, mixer duty and mid-note reset.
module tb_tone_bank;

  localparam int NK = 21;
`ifdef TONE_BANK_MIX_EN
  localparam bit MIX_ON = 1'b1;
`else
  localparam bit MIX_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key;
  logic [1:0]    octave_sel;
  logic [NK-1:0] tone;
  logic [2:0]    active_cnt;
  logic          mix_pwm;

  int checks   = 0;
  int failures = 0;

  tone_bank #(.NUM_KEYS(NK), .CNT_W(20), .MAX_VOICES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .octave_sel (octave_sel),
    .tone       (tone),
    .active_cnt (active_cnt),
    .mix_pwm    (mix_pwm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NK-1:0] key;
    logic [NK-1:0] exp_grant;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int rise [NK];
  int fall20;
  int mix_lo, mix_2, mix_3, mix_4;

  initial begin
    vecs[0] = '{21'h00001F, 21'h00000F};
    vecs[1] = '{21'h00001D, 21'h00001D};
    vecs[2] = '{21'h00001D, 21'h00001D};
    vecs[3] = '{21'h1FFFFF, 21'h00001D};
    vecs[4] = '{21'h1FFFFC, 21'h00003C};
    vecs[5] = '{21'h100401, 21'h100401};
    vecs[6] = '{21'h000000, 21'h000000};
    vecs[7] = '{21'h1FFFFF, 21'h00000F};
    vecs[8] = '{21'h000000, 21'h000000};

    rst = 1'b1; key = '0; octave_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("reset_tone", 32'(tone), 0);
    check("reset_grant", 32'(dut.grant_q), 0);
    check("reset_active", 32'(active_cnt), 0);
    check("reset_mix", 32'(mix_pwm), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      key = vecs[i].key;
      @(negedge clk);
      $display("vec %0d key=%06h grant=%06h expected=%06h", i, key, dut.grant_q, vecs[i].exp_grant);
      check($sformatf("alloc_%0d", i), 32'(dut.grant_q), 32'(vecs[i].exp_grant));
      check($sformatf("alloc_tone_%0d", i), 32'(tone), 0);
    end

    octave_sel = 2'd3;
    @(negedge clk);
    check("oct3_is_base", dut.heff[12], 113636);
    key = 21'h1 << 12;
    @(negedge clk);
    check("grant12", 32'(dut.grant_q), 32'(21'h1 << 12));
    octave_sel = 2'd1;
    repeat (2) @(negedge clk);
    check("oct_ignored_held", dut.heff[12], 113636);
    key = '0;
    @(negedge clk);
    check("release_grant", 32'(dut.grant_q), 0);
    repeat (2) @(negedge clk);
    check("oct_up_loaded", dut.heff[12], 56818);
    octave_sel = 2'd2;
    @(negedge clk);
    check("oct_down_loaded", dut.heff[12], 227272);
    octave_sel = 2'd1;
    @(negedge clk);
    check("oct_up_again", dut.heff[20], 25309);

    // Four voices in the raised octave: rises at 25309/28409/31888/35793.
    for (int k = 0; k < NK; k++) rise[k] = -1;
    fall20 = -1; mix_lo = 0; mix_2 = 0; mix_3 = 0; mix_4 = 0;
    key = 21'hF << 17;
    for (int m = 0; m <= 51000; m++) begin
      @(negedge clk);
      for (int k = 17; k < NK; k++)
        if (rise[k] < 0 && tone[k]) rise[k] = m;
      if (rise[20] >= 0 && fall20 < 0 && !tone[20]) fall20 = m;
      if (m >= 100   && m <= 103)   mix_lo += int'(mix_pwm);
      if (m >= 30001 && m <= 30004) mix_2  += int'(mix_pwm);
      if (m >= 33001 && m <= 33004) mix_3  += int'(mix_pwm);
      if (m >= 40001 && m <= 40004) mix_4  += int'(mix_pwm);
      if (m == 100)   check("act_none", 32'(active_cnt), 0);
      if (m == 30000) check("act_two", 32'(active_cnt), MIX_ON ? 2 : 0);
      if (m == 33000) check("act_three", 32'(active_cnt), MIX_ON ? 3 : 0);
      if (m == 40000) check("act_four", 32'(active_cnt), MIX_ON ? 4 : 0);
    end
    $display("seq rise20=%0d rise19=%0d rise18=%0d rise17=%0d fall20=%0d", rise[20], rise[19], rise[18], rise[17], fall20);
    check("rise20", rise[20], 25309);
    check("rise19", rise[19], 28409);
    check("rise18", rise[18], 31888);
    check("rise17", rise[17], 35793);
    check("fall20", fall20, 50618);
    check("mix_none", mix_lo, 0);
    check("mix_duty2", mix_2, MIX_ON ? 2 : 0);
    check("mix_duty3", mix_3, MIX_ON ? 3 : 0);
    check("mix_duty4", mix_4, MIX_ON ? 4 : 0);
    check("three_high", 32'(tone), 32'(21'h7 << 17));

    rst = 1'b1; key = '0;
    @(negedge clk);
    check("midreset_tone", 32'(tone), 0);
    check("midreset_grant", 32'(dut.grant_q), 0);
    check("midreset_active", 32'(active_cnt), 0);
    check("midreset_mix", 32'(mix_pwm), 0);
    check("midreset_oct", dut.heff[12], 113636);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_tone", 32'(tone), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
